// File: rtl/tm1638_driver.sv
// TM1638 refresh engine: sends 0x40, 0xC0 + 16 data bytes, 0x88|bright, paced by rising edges of clk_div.
// Define KEYSCAN_EN to append the 0x42 key-read frame and expose the keys port.
module tm1638_driver (
  input  logic         clki,
  input  logic         rst,
  input  logic         clk_div,
  input  logic         start,
  input  logic [127:0] seg_data,
  input  logic [2:0]   bright,
  output logic         busy,
  output logic         done,
  output logic         tm_stb,
  output logic         tm_clk,
  output logic         tm_dio_out,
  output logic         tm_dio_oe,
  input  logic         tm_dio_in
`ifdef KEYSCAN_EN
  ,
  output logic [31:0]  keys
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_CMD,
    FRAME_DATA,
    FRAME_CTRL,
`ifdef KEYSCAN_EN
    FRAME_KEY,
`endif
    DONE
  } state_t;

  state_t         state_q, state_d, frame_next;
  logic [8:0]     cnt_q, cnt_d, last_cnt;
  logic [2:0]     sync_q;
  logic           step;
  logic           stb_q, stb_d, clk_q, clk_d, dio_q, dio_d, oe_q, oe_d;
  logic [127:0]   seg_q, seg_d;
  logic [2:0]     bright_q, bright_d;
  logic [135:0]   frame_bits;
  logic [7:0]     bit_idx;
`ifdef KEYSCAN_EN
  logic [31:0]    key_buf_q, key_buf_d, keys_q, keys_d;
  logic [4:0]     rd_idx;
`else
  logic           unused_dio;
  assign unused_dio = tm_dio_in;
`endif

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] remembers the previous value for edge detection
  assign step = sync_q[1] & ~sync_q[2];

  always_comb begin
    frame_bits = '0;
    last_cnt   = 9'd17;
    frame_next = DONE;
    case (state_q)
      FRAME_CMD: begin
        frame_bits[7:0] = 8'h40;
        frame_next      = FRAME_DATA;
      end
      FRAME_DATA: begin
        frame_bits = {seg_q, 8'hC0};
        last_cnt   = 9'd273;
        frame_next = FRAME_CTRL;
      end
      FRAME_CTRL: begin
        frame_bits[7:0] = {5'b10001, bright_q};
`ifdef KEYSCAN_EN
        frame_next      = FRAME_KEY;
`else
        frame_next      = DONE;
`endif
      end
`ifdef KEYSCAN_EN
      FRAME_KEY: begin
        frame_bits[7:0] = 8'h42;
        last_cnt        = 9'd83;
        frame_next      = DONE;
      end
`endif
      default: ;
    endcase
  end

  // Frame step k: 0 lowers STB, odd steps present a bit with CLK low, even steps raise CLK, last raises STB
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stb_d    = stb_q;
    clk_d    = clk_q;
    dio_d    = dio_q;
    oe_d     = oe_q;
    seg_d    = seg_q;
    bright_d = bright_q;
    bit_idx  = 8'((cnt_q - 9'd1) >> 1);
`ifdef KEYSCAN_EN
    key_buf_d = key_buf_q;
    keys_d    = keys_q;
    rd_idx    = 5'((cnt_q - 9'd19) >> 1);
`endif
    case (state_q)
      IDLE, DONE: begin
        stb_d = 1'b1;
        clk_d = 1'b1;
        dio_d = 1'b1;
        oe_d  = 1'b0;
        if (start) begin
          state_d  = FRAME_CMD;
          cnt_d    = 9'd0;
          seg_d    = seg_data;
          bright_d = bright;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (step) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'd0) begin
            stb_d = 1'b0;
            clk_d = 1'b1;
            dio_d = 1'b1;
            oe_d  = 1'b1;
          end else if (cnt_q == last_cnt) begin
            stb_d   = 1'b1;
            clk_d   = 1'b1;
            dio_d   = 1'b1;
            oe_d    = 1'b0;
            cnt_d   = 9'd0;
            state_d = frame_next;
`ifdef KEYSCAN_EN
            if (state_q == FRAME_KEY) keys_d = key_buf_q;
`endif
          end
`ifdef KEYSCAN_EN
          // After the 0x42 byte: two turnaround steps with DIO released, then 32 read bits
          else if (state_q == FRAME_KEY && cnt_q > 9'd16) begin
            oe_d  = 1'b0;
            dio_d = 1'b1;
            if (cnt_q < 9'd19) begin
              clk_d = 1'b1;
            end else if (cnt_q[0]) begin
              clk_d = 1'b0;
            end else begin
              clk_d             = 1'b1;
              key_buf_d[rd_idx] = tm_dio_in;
            end
          end
`endif
          else if (cnt_q[0]) begin
            clk_d = 1'b0;
            dio_d = frame_bits[bit_idx];
            oe_d  = 1'b1;
          end else begin
            clk_d = 1'b1;
            oe_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 9'd0;
      sync_q   <= 3'b000;
      stb_q    <= 1'b1;
      clk_q    <= 1'b1;
      dio_q    <= 1'b1;
      oe_q     <= 1'b0;
      seg_q    <= '0;
      bright_q <= 3'd0;
`ifdef KEYSCAN_EN
      key_buf_q <= 32'd0;
      keys_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= {sync_q[1:0], clk_div};
      stb_q    <= stb_d;
      clk_q    <= clk_d;
      dio_q    <= dio_d;
      oe_q     <= oe_d;
      seg_q    <= seg_d;
      bright_q <= bright_d;
`ifdef KEYSCAN_EN
      key_buf_q <= key_buf_d;
      keys_q    <= keys_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign tm_stb     = stb_q;
  assign tm_clk     = clk_q;
  assign tm_dio_out = dio_q;
  assign tm_dio_oe  = oe_q;
`ifdef KEYSCAN_EN
  assign keys       = keys_q;
`endif

endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: a DIO decoder checks captured bytes, frame sizes and done timing against queued expectations.
// Honours KEYSCAN_EN (key model on tm_dio_in, keys checked at done).
module tb_tm1638_driver;

`ifdef KEYSCAN_EN
  localparam int STEP_TOTAL = 394;
`else
  localparam int STEP_TOTAL = 310;
`endif

  logic         clki = 1'b0;
  logic         rst, clk_div, start;
  logic [127:0] seg_data;
  logic [2:0]   bright;
  logic         busy, done, tm_stb, tm_clk, tm_dio_out, tm_dio_oe, tm_dio_in;
`ifdef KEYSCAN_EN
  logic [31:0]  keys;
`endif

  int errors = 0;
  int checks = 0;
  int div_rises = 0;
  int base_rise = 0;
  bit abort = 1'b1;
  bit fall_pending = 1'b0;
  event div_rise_ev;

  logic [7:0]  exp_bytes[$];
  int          exp_frames[$];
  logic [31:0] exp_done[$];
  logic [31:0] key_vec;
  logic [4:0]  rd_idx = 5'd0;

  assign tm_dio_in = key_vec[rd_idx];

  tm1638_driver dut (
    .clki       (clki),
    .rst        (rst),
    .clk_div    (clk_div),
    .start      (start),
    .seg_data   (seg_data),
    .bright     (bright),
    .busy       (busy),
    .done       (done),
    .tm_stb     (tm_stb),
    .tm_clk     (tm_clk),
    .tm_dio_out (tm_dio_out),
    .tm_dio_oe  (tm_dio_oe),
    .tm_dio_in  (tm_dio_in)
`ifdef KEYSCAN_EN
    ,
    .keys       (keys)
`endif
  );

  always #5 clki = ~clki;

  // clk_div has a 64-cycle period and changes 2 time units after a clki edge
  initial begin
    clk_div = 1'b0;
    forever begin
      repeat (32) @(posedge clki);
      #2 clk_div = ~clk_div;
      if (clk_div) begin
        div_rises++;
        -> div_rise_ev;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input int act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, expected no such event", name, act);
  endtask

  logic       prev_stb = 1'b1, prev_clk = 1'b1, prev_done = 1'b0;
  int         bit_cnt = 0, frame_bytes = 0;
  logic [7:0] shreg = 8'd0;

  // Monitor: decodes the serial bus and pops expectations as bytes, frames and done pulses appear
  always @(negedge clki) begin
    if (abort) begin
      bit_cnt     = 0;
      frame_bytes = 0;
      rd_idx      = 5'd0;
    end else begin
      if (prev_stb && !tm_stb) begin
        bit_cnt     = 0;
        frame_bytes = 0;
        if (fall_pending) begin
          fall_pending = 1'b0;
          check_output("first_stb_fall_step", div_rises - base_rise, 1);
        end
      end
      if (!tm_stb && !prev_clk && tm_clk) begin
        if (tm_dio_oe) begin
          shreg = {tm_dio_out, shreg[7:1]};
          bit_cnt++;
          if (bit_cnt == 8) begin
            bit_cnt = 0;
            frame_bytes++;
            if (exp_bytes.size() == 0) fail_event("unexpected_byte", shreg);
            else check_output("dio_byte", shreg, exp_bytes.pop_front());
          end
        end else begin
          rd_idx = rd_idx + 5'd1;
        end
      end
      if (!prev_stb && tm_stb) begin
        rd_idx = 5'd0;
        if (exp_frames.size() == 0) fail_event("unexpected_frame", frame_bytes);
        else check_output("frame_bytes", frame_bytes + (bit_cnt != 0 ? 100 : 0), exp_frames.pop_front());
      end
      if (done) begin
        if (prev_done) fail_event("done_width", 2);
        else if (exp_done.size() == 0) fail_event("unexpected_done", 1);
        else begin
          check_output("done_step", div_rises - base_rise, STEP_TOTAL);
          check_output("busy_at_done", busy, 1'b0);
`ifdef KEYSCAN_EN
          check_output("keys_at_done", keys, exp_done.pop_front());
`else
          void'(exp_done.pop_front());
`endif
        end
      end
    end
    prev_stb  = tm_stb;
    prev_clk  = tm_clk;
    prev_done = done;
  end

  task automatic push_expect(input logic [127:0] seg, input logic [2:0] br, input logic [31:0] kv);
    exp_bytes.push_back(8'h40);
    exp_frames.push_back(1);
    exp_bytes.push_back(8'hC0);
    for (int k = 0; k < 16; k++) exp_bytes.push_back(seg[8*k +: 8]);
    exp_frames.push_back(17);
    exp_bytes.push_back(8'h88 + {5'd0, br});
    exp_frames.push_back(1);
`ifdef KEYSCAN_EN
    exp_bytes.push_back(8'h42);
    exp_frames.push_back(1);
`endif
    exp_done.push_back(kv);
  endtask

  // Start is sampled n clki edges after a clk_div rise; n=3 lands exactly on that rise's step
  task automatic apply_stimulus(input logic [127:0] seg, input logic [2:0] br, input logic [31:0] kv, input int n);
    seg_data = seg;
    bright   = br;
    key_vec  = kv;
    push_expect(seg, br, kv);
    @(div_rise_ev);
    repeat (n - 1) @(posedge clki);
    #1 start = 1'b1;
    @(posedge clki);
    #1 start = 1'b0;
    base_rise    = div_rises;
    fall_pending = 1'b1;
  endtask

  task automatic wait_steps(input int k);
    int guard = 0;
    while ((div_rises - base_rise) < k && guard < 40000) begin
      @(posedge clki);
      guard++;
    end
    if (guard >= 40000) fail_event("wait_steps_timeout", guard);
    @(posedge clki);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 30000) begin
      @(posedge clki);
      #1;
      guard++;
    end
    if (guard >= 30000) fail_event("wait_idle_timeout", guard);
    repeat (4) @(posedge clki);
    #1;
  endtask

  task automatic check_idle_pins(input string tag);
    check_output({tag, "_stb"}, tm_stb, 1'b1);
    check_output({tag, "_clk"}, tm_clk, 1'b1);
    check_output({tag, "_dio"}, tm_dio_out, 1'b1);
    check_output({tag, "_oe"}, tm_dio_oe, 1'b0);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_done"}, done, 1'b0);
`ifdef KEYSCAN_EN
    check_output({tag, "_keys"}, keys, 32'd0);
`endif
  endtask

  logic [127:0] ramp;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    seg_data = '0;
    bright   = 3'd0;
    key_vec  = 32'd0;
    repeat (3) @(posedge clki);
    #1 check_idle_pins("reset");
    rst = 1'b0;
    repeat (2) @(posedge clki);
    #1 abort = 1'b0;

    // Directed refresh with an input change at step 50 and an ignored start at step 100
    for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k);
    apply_stimulus(ramp, 3'd7, 32'h80001001, 4 + int'($urandom_range(20, 0)));
    wait_steps(50);
    seg_data = '1;
    bright   = 3'd0;
    wait_steps(100);
    check_output("busy_mid_transfer", busy, 1'b1);
    start = 1'b1;
    @(posedge clki);
    #1 start = 1'b0;
    wait_idle();

    // Reset at step 150 aborts the transfer
    apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 3'($urandom), $urandom, 4 + int'($urandom_range(20, 0)));
    wait_steps(150);
    #3 abort = 1'b1;
    rst = 1'b1;
    #1 check_idle_pins("abort");
    exp_bytes.delete();
    exp_frames.delete();
    exp_done.delete();
    fall_pending = 1'b0;
    repeat (3) @(posedge clki);
    #1 rst = 1'b0;
    repeat (2) @(posedge clki);
    #1 abort = 1'b0;
    repeat (200) @(posedge clki);
    #1 check_output("idle_after_abort", busy, 1'b0);

    // Start coinciding with a step: the frame must wait for the following step
    apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 3'($urandom), $urandom, 3);
    check_output("stb_not_current_step", tm_stb, 1'b1);
    check_output("busy_after_start", busy, 1'b1);
    wait_idle();

    apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 3'($urandom), $urandom, 4 + int'($urandom_range(24, 0)));
    wait_idle();

    check_output("bytes_left", exp_bytes.size(), 0);
    check_output("dones_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm1638_driver.md
TM1638_DRIVER -- requirements
Module: tm1638_driver

Interface
REQ-001 SHALL have port clki, input, 1: system clock; all state advances on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port clk_div, input, 1: divided clock from the clock divider; the block uses it as a pace source only, never as a clock.
REQ-004 SHALL have port start, input, 1: one-cycle request to refresh the display.
REQ-005 SHALL have port seg_data, input, 128: sixteen display bytes; byte k is seg_data[8k+7:8k] and maps to TM1638 address k.
REQ-006 SHALL have port bright, input, 3: brightness level for the display-control command.
REQ-007 SHALL have port busy, output, 1: high from the accepted start until done.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the refresh is complete.
REQ-009 SHALL have ports tm_stb, tm_clk and tm_dio_out, outputs, 1 each: TM1638 STB, CLK and DIO drive value.
REQ-010 SHALL have port tm_dio_oe, output, 1: DIO output enable (1 = drive).
REQ-011 SHALL have port tm_dio_in, input, 1: DIO sampled value.
REQ-012 SHALL have port keys, output, 32: key-scan bytes 0..3 at keys[8k+7:8k]; present only with KEYSCAN_EN.

Function
REQ-013 SHALL synchronise clk_div through two flops and generate a one-clki-cycle step on every 0->1 transition; all serial timing SHALL advance only on step.
REQ-014 SHALL accept start only when busy=0; SHALL ignore start while busy=1.
REQ-015 SHALL latch seg_data and bright on the accepted start; later input changes SHALL NOT affect the transfer in progress.
REQ-016 SHALL set busy on the clki edge that accepts start; the first frame SHALL begin on the next step.
REQ-017 SHALL implement an FSM with states IDLE, FRAME_CMD (0x40), FRAME_DATA (0xC0 followed by 16 data bytes), FRAME_CTRL (0x88 | bright), [FRAME_KEY], and DONE, executed in that order.
REQ-018 SHALL time each n-byte frame as 16n+2 steps: step 0 drives tm_stb=0; steps 1..16n carry the bits; the step after the last bit drives tm_stb=1; the frame then holds tm_stb high for one further step.
REQ-019 SHALL use two steps per bit: on the first, tm_clk=0 and tm_dio_out=bit; on the second, tm_clk=1. Bytes SHALL be sent LSB first, with data byte 0 first.
REQ-020 SHALL, without KEYSCAN_EN, complete in 18+274+18 = 310 steps.
REQ-021 SHALL pulse done for one clki cycle on the cycle after the final step, clear busy in that same cycle, and return to IDLE.
REQ-022 SHALL, while in IDLE, drive tm_stb=1, tm_clk=1, tm_dio_out=1 and tm_dio_oe=0.
REQ-023 SHALL hold tm_dio_oe=1 for all write bits.
REQ-024 SHALL emit no step when start coincides with a step; the frame SHALL begin at the next step.

Reset
REQ-025 SHALL, on rst=1 and asynchronously, force IDLE with busy=0, done=0, tm_stb=1, tm_clk=1, tm_dio_out=1, tm_dio_oe=0, keys=0 and the synchroniser flops at 0.
REQ-026 SHALL, when rst is asserted mid-transfer, abort the transfer immediately with no done pulse; after release, SHALL wait for a fresh start.

Configuration
REQ-027 SHALL, with KEYSCAN_EN defined, append FRAME_KEY after FRAME_CTRL with this sequence:
- send command 0x42 (16 steps);
- release DIO (tm_dio_oe=0) for 2 wait steps with tm_clk=1;
- read 4 bytes LSB first, sampling tm_dio_in on each tm_clk rising step;
- update keys in a single cycle with done;
- frame length 84 steps, total 394 steps.
REQ-028 SHALL, without KEYSCAN_EN, omit the keys port and the FRAME_KEY logic.

Verification
REQ-029 Bench SHALL drive clk_div with period 64 clki, seg_data = bytes 0x00..0x0F, bright=7, and one start pulse -> the DIO decoder captures 0x40 / 0xC0,00..0F / 0x8F; done occurs exactly 310 steps later.
REQ-030 Bench SHALL pulse start again at step 100 of an active transfer -> it is ignored; exactly one done pulse occurs.
REQ-031 Bench SHALL change seg_data to all-ones at step 50 -> the captured data bytes remain 0x00..0x0F.
REQ-032 Bench SHALL assert rst at step 150 -> outputs immediately reach the idle levels, with no done pulse; a later start produces a full correct refresh.
REQ-033 Bench SHALL, with KEYSCAN_EN and a key model returning 0x01,0x10,0x00,0x80 -> observe keys=0x80001001 together with done at step 394.
REQ-034 Bench SHALL assert start in the same cycle as a step -> tm_stb falls at the following step, not the current one.
